// File: rtl/billiard_pkg.sv
// -----------------------------------------------------------------------------
// billiard_pkg
//   Shared types and helpers for the billiard collision sequencer.
//   - evt_type_t    : event type code carried on the event port
//   - BALL_WHITE/RED: ball select code carried on the event port
//   - sched_state_t : sequencer FSM states
//   - first_hole()  : index of the lowest set hole drawing request
// -----------------------------------------------------------------------------
package billiard_pkg;

  typedef enum logic [1:0] {
    EVT_NONE   = 2'd0,
    EVT_BORDER = 2'd1,
    EVT_BALL   = 2'd2,
    EVT_HOLE   = 2'd3
  } evt_type_t;

  localparam logic BALL_WHITE = 1'b0;
  localparam logic BALL_RED   = 1'b1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    GAP     = 2'd2
  } sched_state_t;

  // Hole request vectors are widened to this size before the index search.
  localparam int MAX_HOLES = 8;

  // Lowest set bit index of a hole request vector; 0 when the vector is empty.
  // Scanning from the top down leaves the lowest hit as the final assignment.
  function automatic logic [2:0] first_hole(input logic [MAX_HOLES-1:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = MAX_HOLES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ball_event_tracker.sv
// -----------------------------------------------------------------------------
// ball_event_tracker
//   Per-ball collision bookkeeping: sticky collect flags for the current frame,
//   the hole index of the first hole hit, the single pending event selected at
//   the frame snapshot (HOLE > BALL > BORDER), and the pocketed bit.
//
// Ports
//   clk, resetN    clock, asynchronous active-low reset
//   clear          re-rack: drops pocketed, collect and pending state
//   snap           frame snapshot strobe (already qualified against clear)
//   ball_dr        raw drawing request of this ball
//   ball_hit       white and red (both pocket-masked) drawn on the same pixel
//   border_dr      border drawing request
//   hole_dr        per-hole drawing requests
//   take           sequencer launches this ball's offered event this cycle
//   pocket         this ball's HOLE event was acknowledged
//   masked_dr      ball_dr with pocketing applied
//   pocketed       sticky pocketed flag (registered)
//   offer_valid/offer_type/offer_hole
//                  event this ball would launch now: the live snapshot
//                  selection during snap, otherwise the pending register
// -----------------------------------------------------------------------------
module ball_event_tracker
  import billiard_pkg::*;
#(
  parameter int NUM_HOLES = 6
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 clear,
  input  logic                 snap,
  input  logic                 ball_dr,
  input  logic                 ball_hit,
  input  logic                 border_dr,
  input  logic [NUM_HOLES-1:0] hole_dr,
  input  logic                 take,
  input  logic                 pocket,
  output logic                 masked_dr,
  output logic                 pocketed,
  output logic                 offer_valid,
  output logic [1:0]           offer_type,
  output logic [2:0]           offer_hole
);

  logic            border_flag_r;
  logic            ball_flag_r;
  logic            hole_flag_r;
  logic [2:0]      hole_idx_r;
  logic            pend_valid_r;
  evt_type_t       pend_type_r;
  logic [2:0]      pend_hole_r;
  logic            pocketed_r;

  logic            masked_dr_s;
  logic            border_hit_s;
  logic            hole_hit_s;
  logic [MAX_HOLES-1:0] hole_vec_s;
  logic [2:0]      hit_idx_s;
  logic            sel_valid_s;
  evt_type_t       sel_type_s;
  logic [2:0]      sel_hole_s;

  assign masked_dr_s  = ball_dr & ~pocketed_r;
  assign border_hit_s = masked_dr_s & border_dr;
  assign hole_hit_s   = masked_dr_s & (|hole_dr);
  assign hole_vec_s   = MAX_HOLES'(hole_dr);
  assign hit_idx_s    = first_hole(hole_vec_s);

  assign masked_dr    = masked_dr_s;
  assign pocketed     = pocketed_r;

  // Highest-priority event among the flags collected so far this frame.
  always_comb begin
    sel_valid_s = 1'b1;
    sel_type_s  = EVT_NONE;
    sel_hole_s  = 3'd0;
    if (hole_flag_r) begin
      sel_type_s = EVT_HOLE;
      sel_hole_s = hole_idx_r;
    end else if (ball_flag_r) begin
      sel_type_s = EVT_BALL;
    end else if (border_flag_r) begin
      sel_type_s = EVT_BORDER;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  // During a snapshot the fresh selection supersedes any stale pending event,
  // so the sequencer can launch it in the same cycle.
  always_comb begin
    offer_valid = 1'b0;
    offer_type  = EVT_NONE;
    offer_hole  = 3'd0;
    if (snap) begin
      offer_valid = sel_valid_s;
      offer_type  = sel_type_s;
      offer_hole  = sel_hole_s;
    end else begin
      offer_valid = pend_valid_r;
      offer_type  = pend_type_r;
      offer_hole  = pend_hole_r;
    end
  end

  // Sticky collect flags; a hit in the snapshot cycle belongs to the new frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      border_flag_r <= 1'b0;
      ball_flag_r   <= 1'b0;
      hole_flag_r   <= 1'b0;
      hole_idx_r    <= 3'd0;
    end else if (clear || pocket) begin
      border_flag_r <= 1'b0;
      ball_flag_r   <= 1'b0;
      hole_flag_r   <= 1'b0;
      hole_idx_r    <= 3'd0;
    end else if (snap) begin
      border_flag_r <= border_hit_s;
      ball_flag_r   <= ball_hit;
      hole_flag_r   <= hole_hit_s;
      hole_idx_r    <= hole_hit_s ? hit_idx_s : 3'd0;
    end else begin
      border_flag_r <= border_flag_r | border_hit_s;
      ball_flag_r   <= ball_flag_r | ball_hit;
      hole_flag_r   <= hole_flag_r | hole_hit_s;
      // Only the first hole hit of the frame records its index.
      if (hole_hit_s && !hole_flag_r) begin
        hole_idx_r <= hit_idx_s;
      end else begin
        hole_idx_r <= hole_idx_r;
      end
    end
  end

  // Pending event: cleared when launched (the event then lives in the
  // sequencer's output registers), reloaded at each snapshot.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pend_valid_r <= 1'b0;
      pend_type_r  <= EVT_NONE;
      pend_hole_r  <= 3'd0;
    end else if (clear || pocket || take) begin
      pend_valid_r <= 1'b0;
      pend_type_r  <= EVT_NONE;
      pend_hole_r  <= 3'd0;
    end else if (snap) begin
      pend_valid_r <= sel_valid_s;
      pend_type_r  <= sel_type_s;
      pend_hole_r  <= sel_hole_s;
    end else begin
      pend_valid_r <= pend_valid_r;
      pend_type_r  <= pend_type_r;
      pend_hole_r  <= pend_hole_r;
    end
  end

  // Pocketed bit: set by an acknowledged HOLE event, cleared only by re-rack.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pocketed_r <= 1'b0;
    end else if (clear) begin
      pocketed_r <= 1'b0;
    end else if (pocket) begin
      pocketed_r <= 1'b1;
    end else begin
      pocketed_r <= pocketed_r;
    end
  end

endmodule

// File: rtl/collision_scheduler.sv
// -----------------------------------------------------------------------------
// collision_scheduler
//   Frame-level collision sequencer for the billiard game. Two
//   ball_event_tracker instances gather collision flags during the scan; at
//   startOfFrame the flags are snapshotted and one event per ball is issued
//   (white before red) over the evtReq/evtAck handshake.
//
// Optional feature (macro SCHED_TIMEOUT_EN): an ISSUE that waits ACK_TIMEOUT
//   cycles without evtAck drops its event (no pocketing) and pulses overrun.
//   With the macro undefined ISSUE waits indefinitely and the ACK_TIMEOUT
//   parameter does not exist.
//
// Ports
//   clk, resetN      clock, asynchronous active-low reset
//   startOfFrame     frame start pulse (snapshot)
//   newRack          re-rack pulse; wins over startOfFrame
//   whiteBallDR, redBallDR, borderDR, holeDR   pixel drawing requests
//   evtReq/evtBall/evtType/evtHole             registered event port
//   evtAck           consumer accepts the event (only seen in ISSUE)
//   whitePocketed, redPocketed                 sticky pocketed flags
//   overrun          one-cycle pulse: frame started while busy, or timeout
//   busy             FSM outside COLLECT
// -----------------------------------------------------------------------------
module collision_scheduler
  import billiard_pkg::*;
#(
  parameter int NUM_HOLES   = 6
`ifdef SCHED_TIMEOUT_EN
  ,
  parameter int ACK_TIMEOUT = 15
`endif
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 newRack,
  input  logic                 whiteBallDR,
  input  logic                 redBallDR,
  input  logic                 borderDR,
  input  logic [NUM_HOLES-1:0] holeDR,
  output logic                 evtReq,
  output logic                 evtBall,
  output logic [1:0]           evtType,
  output logic [2:0]           evtHole,
  input  logic                 evtAck,
  output logic                 whitePocketed,
  output logic                 redPocketed,
  output logic                 overrun,
  output logic                 busy
);

  sched_state_t state_r;
  logic         evt_req_r;
  logic         evt_ball_r;
  evt_type_t    evt_type_r;
  logic [2:0]   evt_hole_r;
  logic         overrun_r;
  logic         busy_r;

  logic         sof_s;
  logic         w_masked_s;
  logic         r_masked_s;
  logic         ball_hit_s;
  logic         w_offer_valid_s;
  logic [1:0]   w_offer_type_s;
  logic [2:0]   w_offer_hole_s;
  logic         r_offer_valid_s;
  logic [1:0]   r_offer_type_s;
  logic [2:0]   r_offer_hole_s;
  logic         launch_s;
  logic         w_take_s;
  logic         r_take_s;
  logic         ack_s;
  logic         w_pocket_s;
  logic         r_pocket_s;
  logic         timeout_s;
  logic         nxt_ball_s;
  evt_type_t    nxt_type_s;
  logic [2:0]   nxt_hole_s;

  // Re-rack outranks a coincident frame start.
  assign sof_s      = startOfFrame & ~newRack;
  assign ball_hit_s = w_masked_s & r_masked_s;

  // A launch happens from COLLECT or GAP whenever either ball offers an event.
  assign launch_s = ((state_r == COLLECT) || (state_r == GAP)) &&
                    (w_offer_valid_s || r_offer_valid_s) && !newRack;
  assign w_take_s = launch_s & w_offer_valid_s;
  assign r_take_s = launch_s & ~w_offer_valid_s & r_offer_valid_s;

  assign ack_s      = (state_r == ISSUE) && evtAck && !newRack;
  assign w_pocket_s = ack_s && (evt_type_r == EVT_HOLE) && (evt_ball_r == BALL_WHITE);
  assign r_pocket_s = ack_s && (evt_type_r == EVT_HOLE) && (evt_ball_r == BALL_RED);

  ball_event_tracker #(.NUM_HOLES(NUM_HOLES)) u_white (
    .clk         (clk),
    .resetN      (resetN),
    .clear       (newRack),
    .snap        (sof_s),
    .ball_dr     (whiteBallDR),
    .ball_hit    (ball_hit_s),
    .border_dr   (borderDR),
    .hole_dr     (holeDR),
    .take        (w_take_s),
    .pocket      (w_pocket_s),
    .masked_dr   (w_masked_s),
    .pocketed    (whitePocketed),
    .offer_valid (w_offer_valid_s),
    .offer_type  (w_offer_type_s),
    .offer_hole  (w_offer_hole_s)
  );

  ball_event_tracker #(.NUM_HOLES(NUM_HOLES)) u_red (
    .clk         (clk),
    .resetN      (resetN),
    .clear       (newRack),
    .snap        (sof_s),
    .ball_dr     (redBallDR),
    .ball_hit    (ball_hit_s),
    .border_dr   (borderDR),
    .hole_dr     (holeDR),
    .take        (r_take_s),
    .pocket      (r_pocket_s),
    .masked_dr   (r_masked_s),
    .pocketed    (redPocketed),
    .offer_valid (r_offer_valid_s),
    .offer_type  (r_offer_type_s),
    .offer_hole  (r_offer_hole_s)
  );

  // White-before-red arbitration of the event to launch.
  always_comb begin
    nxt_ball_s = BALL_WHITE;
    nxt_type_s = EVT_NONE;
    nxt_hole_s = 3'd0;
    if (w_offer_valid_s) begin
      nxt_ball_s = BALL_WHITE;
      nxt_type_s = evt_type_t'(w_offer_type_s);
      nxt_hole_s = w_offer_hole_s;
    end else begin
      nxt_ball_s = BALL_RED;
      nxt_type_s = evt_type_t'(r_offer_type_s);
      nxt_hole_s = r_offer_hole_s;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  logic [3:0] ack_wait_r;

  // Number of the current ISSUE cycle; 1 in the first cycle evtReq is high.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ack_wait_r <= 4'd0;
    end else if (newRack) begin
      ack_wait_r <= 4'd0;
    end else if (launch_s) begin
      ack_wait_r <= 4'd1;
    end else if ((state_r == ISSUE) && (ack_wait_r != 4'd15)) begin
      ack_wait_r <= ack_wait_r + 4'd1;
    end else begin
      ack_wait_r <= ack_wait_r;
    end
  end

  // An ack in the final waiting cycle still wins over the timeout.
  assign timeout_s = (state_r == ISSUE) && !evtAck && !newRack &&
                     (ack_wait_r == 4'(ACK_TIMEOUT));
`else
  assign timeout_s = 1'b0;
`endif

  // Sequencer FSM with registered event port, busy and overrun.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r    <= COLLECT;
      evt_req_r  <= 1'b0;
      evt_ball_r <= 1'b0;
      evt_type_r <= EVT_NONE;
      evt_hole_r <= 3'd0;
      overrun_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else if (newRack) begin
      state_r    <= COLLECT;
      evt_req_r  <= 1'b0;
      evt_ball_r <= 1'b0;
      evt_type_r <= EVT_NONE;
      evt_hole_r <= 3'd0;
      overrun_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      overrun_r <= (sof_s && (state_r != COLLECT)) || timeout_s;
      case (state_r)
        COLLECT, GAP: begin
          if (launch_s) begin
            state_r    <= ISSUE;
            evt_req_r  <= 1'b1;
            evt_ball_r <= nxt_ball_s;
            evt_type_r <= nxt_type_s;
            evt_hole_r <= nxt_hole_s;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= COLLECT;
            evt_req_r  <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        ISSUE: begin
          // Event fields stay frozen until the handshake ends.
          if (ack_s || timeout_s) begin
            state_r   <= GAP;
            evt_req_r <= 1'b0;
            busy_r    <= 1'b1;
          end else begin
            state_r   <= ISSUE;
            evt_req_r <= 1'b1;
            busy_r    <= 1'b1;
          end
        end
        default: begin
          state_r   <= COLLECT;
          evt_req_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign evtReq  = evt_req_r;
  assign evtBall = evt_ball_r;
  assign evtType = evt_type_r;
  assign evtHole = evt_hole_r;
  assign overrun = overrun_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_collision_scheduler.sv
// -----------------------------------------------------------------------------
// tb_collision_scheduler
//   Directed bench for collision_scheduler (default build). Inputs change and
//   outputs are sampled 1 ns after each rising edge; "cycle N" is the cycle in
//   which startOfFrame is held high.
// -----------------------------------------------------------------------------
module tb_collision_scheduler;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       newRack;
  logic       whiteBallDR;
  logic       redBallDR;
  logic       borderDR;
  logic [5:0] holeDR;
  logic       evtReq;
  logic       evtBall;
  logic [1:0] evtType;
  logic [2:0] evtHole;
  logic       evtAck;
  logic       whitePocketed;
  logic       redPocketed;
  logic       overrun;
  logic       busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  collision_scheduler #(.NUM_HOLES(6)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .newRack       (newRack),
    .whiteBallDR   (whiteBallDR),
    .redBallDR     (redBallDR),
    .borderDR      (borderDR),
    .holeDR        (holeDR),
    .evtReq        (evtReq),
    .evtBall       (evtBall),
    .evtType       (evtType),
    .evtHole       (evtHole),
    .evtAck        (evtAck),
    .whitePocketed (whitePocketed),
    .redPocketed   (redPocketed),
    .overrun       (overrun),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_dr();
    whiteBallDR = 1'b0;
    redBallDR   = 1'b0;
    borderDR    = 1'b0;
    holeDR      = 6'b000000;
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    newRack      = 1'b0;
    evtAck       = 1'b0;
    clear_dr();
    idle(2);

    // ---------------- reset state ----------------
    check_eq("rst_req",  32'(evtReq), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ovr",  32'(overrun), 32'd0);
    check_eq("rst_wpk",  32'(whitePocketed), 32'd0);
    check_eq("rst_rpk",  32'(redPocketed), 32'd0);
    check_eq("rst_type", 32'(evtType), 32'd0);
    resetN = 1'b1;
    idle(2);

    // ---------------- A: white/border, ack at N+3 ----------------
    whiteBallDR = 1'b1; borderDR = 1'b1;
    idle(3);
    clear_dr();
    idle(2);
    startOfFrame = 1'b1;                 // cycle N
    tick();                              // N+1
    startOfFrame = 1'b0;
    check_eq("A_req_n1",  32'(evtReq), 32'd1);
    check_eq("A_ball",    32'(evtBall), 32'd0);
    check_eq("A_type",    32'(evtType), 32'd1);
    check_eq("A_busy_n1", 32'(busy), 32'd1);
    tick();                              // N+2
    check_eq("A_req_n2",  32'(evtReq), 32'd1);
    tick();                              // N+3
    evtAck = 1'b1;
    check_eq("A_req_n3",  32'(evtReq), 32'd1);
    tick();                              // N+4
    evtAck = 1'b0;
    check_eq("A_req_n4",  32'(evtReq), 32'd0);
    check_eq("A_busy_n4", 32'(busy), 32'd1);
    tick();                              // N+5
    check_eq("A_busy_n5", 32'(busy), 32'd0);
    check_eq("A_req_n5",  32'(evtReq), 32'd0);
    idle(2);

    // ---------------- B: red hole beats border, pocketing ----------------
    redBallDR = 1'b1; holeDR = 6'b001100;
    tick();
    holeDR = 6'b000000; borderDR = 1'b1;
    tick();
    clear_dr();
    idle(2);
    startOfFrame = 1'b1;
    tick();                              // N+1
    startOfFrame = 1'b0;
    check_eq("B_req",  32'(evtReq), 32'd1);
    check_eq("B_ball", 32'(evtBall), 32'd1);
    check_eq("B_type", 32'(evtType), 32'd3);
    check_eq("B_hole", 32'(evtHole), 32'd2);
    evtAck = 1'b1;
    tick();                              // N+2
    evtAck = 1'b0;
    check_eq("B_req_gap", 32'(evtReq), 32'd0);
    check_eq("B_rpk",     32'(redPocketed), 32'd1);
    tick();                              // N+3: border was discarded
    check_eq("B_busy_end", 32'(busy), 32'd0);
    redBallDR = 1'b1; borderDR = 1'b1;
    idle(2);
    clear_dr();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    check_eq("B_masked_req",  32'(evtReq), 32'd0);
    check_eq("B_masked_busy", 32'(busy), 32'd0);
    newRack = 1'b1;
    tick();
    newRack = 1'b0;
    check_eq("B_rack_rpk", 32'(redPocketed), 32'd0);
    idle(2);

    // ---------------- C: ball-ball, white then red ----------------
    whiteBallDR = 1'b1; redBallDR = 1'b1;
    tick();
    clear_dr();
    idle(2);
    startOfFrame = 1'b1;
    tick();                              // N+1
    startOfFrame = 1'b0;
    check_eq("C_req1",  32'(evtReq), 32'd1);
    check_eq("C_ball1", 32'(evtBall), 32'd0);
    check_eq("C_type1", 32'(evtType), 32'd2);
    evtAck = 1'b1;
    tick();                              // N+2 GAP
    evtAck = 1'b0;
    check_eq("C_gap_req",  32'(evtReq), 32'd0);
    check_eq("C_gap_busy", 32'(busy), 32'd1);
    tick();                              // N+3
    check_eq("C_req2",  32'(evtReq), 32'd1);
    check_eq("C_ball2", 32'(evtBall), 32'd1);
    check_eq("C_type2", 32'(evtType), 32'd2);
    evtAck = 1'b1;
    tick();                              // N+4
    evtAck = 1'b0;
    check_eq("C_req_end", 32'(evtReq), 32'd0);
    tick();                              // N+5
    check_eq("C_busy_end", 32'(busy), 32'd0);
    idle(2);

    // ---------------- D: overrun while white is in flight ----------------
    whiteBallDR = 1'b1; borderDR = 1'b1;
    tick();
    clear_dr();
    idle(2);
    startOfFrame = 1'b1;
    tick();                              // N+1
    startOfFrame = 1'b0;
    check_eq("D_req1",  32'(evtReq), 32'd1);
    check_eq("D_ovr_n1", 32'(overrun), 32'd0);
    redBallDR = 1'b1; borderDR = 1'b1;
    tick();                              // N+2
    tick();                              // N+3
    clear_dr();
    startOfFrame = 1'b1;
    tick();                              // N+4
    startOfFrame = 1'b0;
    check_eq("D_ovr_pulse", 32'(overrun), 32'd1);
    check_eq("D_req_hold",  32'(evtReq), 32'd1);
    check_eq("D_ball_hold", 32'(evtBall), 32'd0);
    check_eq("D_type_hold", 32'(evtType), 32'd1);
    tick();                              // N+5
    check_eq("D_ovr_clr", 32'(overrun), 32'd0);
    evtAck = 1'b1;
    tick();                              // N+6 GAP
    evtAck = 1'b0;
    check_eq("D_gap_req", 32'(evtReq), 32'd0);
    tick();                              // N+7
    check_eq("D_req2",  32'(evtReq), 32'd1);
    check_eq("D_ball2", 32'(evtBall), 32'd1);
    check_eq("D_type2", 32'(evtType), 32'd1);
    evtAck = 1'b1;
    tick();                              // N+8
    evtAck = 1'b0;
    tick();                              // N+9
    check_eq("D_busy_end", 32'(busy), 32'd0);
    idle(2);

    // ---------------- E: newRack during ISSUE ----------------
    whiteBallDR = 1'b1; holeDR = 6'b100000;
    tick();
    whiteBallDR = 1'b0; redBallDR = 1'b1; holeDR = 6'b000001;
    tick();
    clear_dr();
    idle(2);
    startOfFrame = 1'b1;
    tick();                              // N+1
    startOfFrame = 1'b0;
    check_eq("E_ball1", 32'(evtBall), 32'd0);
    check_eq("E_type1", 32'(evtType), 32'd3);
    check_eq("E_hole1", 32'(evtHole), 32'd5);
    evtAck = 1'b1;
    tick();                              // N+2
    evtAck = 1'b0;
    check_eq("E_wpk", 32'(whitePocketed), 32'd1);
    tick();                              // N+3
    check_eq("E_req2",  32'(evtReq), 32'd1);
    check_eq("E_ball2", 32'(evtBall), 32'd1);
    check_eq("E_hole2", 32'(evtHole), 32'd0);
    newRack = 1'b1;
    tick();                              // N+4
    newRack = 1'b0;
    check_eq("E_rack_req",  32'(evtReq), 32'd0);
    check_eq("E_rack_busy", 32'(busy), 32'd0);
    check_eq("E_rack_wpk",  32'(whitePocketed), 32'd0);
    check_eq("E_rack_rpk",  32'(redPocketed), 32'd0);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    check_eq("E_empty_req", 32'(evtReq), 32'd0);
    idle(2);

    // ---------------- F: asynchronous reset mid-ISSUE ----------------
    whiteBallDR = 1'b1; borderDR = 1'b1;
    tick();
    clear_dr();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check_eq("F_req_pre", 32'(evtReq), 32'd1);
    #2;
    resetN = 1'b0;
    #1;
    check_eq("F_req_async",  32'(evtReq), 32'd0);
    check_eq("F_busy_async", 32'(busy), 32'd0);
    check_eq("F_type_async", 32'(evtType), 32'd0);
    tick();
    resetN = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
- Frame-level sequencer for collision handling in the billiard game.
- Watches per-pixel drawing requests during the VGA scan and records collision events per ball as sticky flags.
- At each start of frame, snapshots the flags and issues the events one at a time, by priority, over a req/ack handshake to the ball velocity/response datapath.
- Tracks pocketed balls, so a pocketed ball generates no further events until the table is re-racked.

Parameters:
- NUM_HOLES, 6, number of hole drawing-request inputs; the hole index is 3 bits.
- ACK_TIMEOUT, 15, cycles evtReq may wait for evtAck before the event is dropped (used only with the optional feature).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  single-cycle pulse at frame start
- newRack  in  1  single-cycle pulse; clears pocketed state and all flags
- whiteBallDR  in  1  white ball pixel drawing request
- redBallDR  in  1  red ball pixel drawing request
- borderDR  in  1  border pixel drawing request
- holeDR  in  NUM_HOLES  per-hole drawing requests
- evtReq  out  1  event valid
- evtBall  out  1  0 = white, 1 = red
- evtType  out  2  1 = BORDER, 2 = BALL, 3 = HOLE (0 unused)
- evtHole  out  3  hole index; valid when evtType = HOLE
- evtAck  in  1  consumer accepts the event
- whitePocketed  out  1  sticky: white ball is in a hole
- redPocketed  out  1  sticky: red ball is in a hole
- overrun  out  1  one-cycle pulse: a frame began while events were still pending
- busy  out  1  high in any state other than COLLECT

Behaviour:
- Reset: all outputs 0, all flags cleared, state COLLECT.
- Collect (every cycle, any state):
  - Ball X raises flag xBorder when X_DR & borderDR.
  - Both balls raise flag xBall when whiteBallDR & redBallDR.
  - Ball X raises flag xHole when X_DR & holeDR[i]; xHoleIdx latches the lowest set i, on the first hit of the frame only.
  - While xPocketed = 1, X_DR is masked to 0.
- Snapshot on startOfFrame:
  - Collect flags copy into pending registers.
  - Collect flags clear in the same cycle; a DR coincident with startOfFrame counts toward the new frame.
- One event per ball per frame, selected by priority HOLE > BALL > BORDER. Lower-priority pending bits for that ball are discarded at the snapshot.
- Issue order: white first, then red.
- FSM states:
  - COLLECT: if any bit is pending, go to ISSUE on the next cycle, so evtReq rises at N+1 after the startOfFrame cycle N.
  - ISSUE: evtReq = 1. evtBall, evtType and evtHole are registered and stable until evtAck is sampled high. On ack: the pending bit clears, and if the acked type is HOLE, xPocketed is set. Then go to GAP.
  - GAP: evtReq = 0 for exactly one cycle. Go to ISSUE if anything remains pending, else COLLECT.
  - evtAck outside ISSUE is ignored.
- startOfFrame while busy:
  - The in-flight event (ISSUE) completes normally.
  - Unissued pending bits are overwritten by the new snapshot.
  - overrun pulses for one cycle.
- newRack: takes priority over startOfFrame in the same cycle. Clears the pocketed, collect and pending state, drops evtReq immediately, and sends the FSM to COLLECT.
- Reset mid-handshake: evtReq drops asynchronously; the consumer must tolerate this.

Optional Feature:
- Macro SCHED_TIMEOUT_EN.
- Defined:
  - A 4-bit counter runs while in ISSUE.
  - If it reaches ACK_TIMEOUT with no ack, the event is dropped: pending bit cleared, no pocketing, overrun pulses, go to GAP.
  - evtAck arriving in that same cycle wins over the timeout.
- Undefined: ISSUE waits indefinitely; the counter logic is absent.

Decomposition:
- Shared package billiard_pkg:
  - evt_type_t enum (EVT_NONE = 0, EVT_BORDER = 1, EVT_BALL = 2, EVT_HOLE = 3).
  - BALL_WHITE / BALL_RED constants.
  - sched_state_t enum (COLLECT, ISSUE, GAP).
- One natural sub-module, ball_event_tracker, instantiated twice (white, red). It owns one ball's collect flags, hole index, pending selection and pocketed bit. The top level holds the FSM and the white/red arbitration.

Test Plan:
- white DR & border DR for 3 cycles mid-frame, then startOfFrame at N, ack at N+3 -> evtReq rises at N+1 with evtBall=0, evtType=1; evtReq falls at N+4; busy returns to 0 at N+5.
- red DR & holeDR = 6'b001100 plus red DR & border DR in the same frame, then startOfFrame, ack -> single event evtBall=1, evtType=3, evtHole=2; redPocketed=1; red DR & border DR afterwards produce no events.
- white DR & red DR overlap, then startOfFrame -> two events: (white, BALL), one-cycle GAP, (red, BALL), in that order.
- Events pending, no ack, second startOfFrame -> overrun pulses 1 cycle, the in-flight event stays stable, the next event reflects the new frame's flags.
- With SCHED_TIMEOUT_EN defined, no ack for 15 cycles -> evtReq drops, overrun pulses, no pocketing; ack in cycle 15 -> normal accept.
- newRack during ISSUE -> evtReq drops the next edge, pocketed bits cleared, FSM in COLLECT; resetN low mid-ISSUE -> all outputs 0 asynchronously.
